// File: rtl/croc_pkg.sv
`default_nettype none
// ============================================================================
// croc_pkg -- shared types for the croc boot controller
// Rev 1.0
// ============================================================================
package croc_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    RST_HOLD  = 3'd1,
    IDLE      = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4,
    TIMEOUT   = 3'd5
  } boot_state_e;

  localparam int unsigned c_cnt_width = 32;

endpackage
`default_nettype wire

// File: rtl/croc_debounce.sv
`default_nettype none
// ============================================================================
// croc_debounce -- accepts a new level after Cycles consecutive mismatches
// Rev 1.0
// ============================================================================
module croc_debounce
  import croc_pkg::*;
#(
  parameter int unsigned Cycles = 20000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam logic [c_cnt_width-1:0] c_last = c_cnt_width'(Cycles - 1);

  logic [c_cnt_width-1:0] r_cnt;
  logic                   r_q;

  // Any cycle where the input agrees with the accepted level restarts the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (d_i == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_q   <= d_i;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/croc_boot_ctrl.sv
`default_nettype none
// ============================================================================
// croc_boot_ctrl -- sequences SoC reset and fetch enable from lock and switch
// Rev 1.0
// ============================================================================
module croc_boot_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned RstHoldCycles  = 32,
  parameter int unsigned DebounceCycles = 20000,
  parameter int unsigned TimeoutCycles  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        locked_i,
  input  logic        fetch_sw_i,
  input  logic        restart_i,
  input  logic        status_i,
  output logic        soc_rst_o,
  output logic        fetch_en_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [2:0]  state_o,
  output logic [31:0] run_cycles_o
);

  localparam logic [c_cnt_width-1:0] c_hold_last    = c_cnt_width'(RstHoldCycles - 1);
  localparam logic [c_cnt_width-1:0] c_timeout_last = c_cnt_width'(TimeoutCycles - 1);
  localparam logic                   c_timeout_en   = (TimeoutCycles != 0);

  logic                   r_lock_s1, r_lock_s2;
  logic                   r_sw_s1, r_sw_s2;
  logic                   w_sw_db;
  boot_state_e            r_state, w_state_next;
  logic [c_cnt_width-1:0] r_hold_cnt;
  logic [31:0]            r_run_cycles;
  logic                   w_hold_clr, w_run_clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_sw_s1   <= 1'b0;
      r_sw_s2   <= 1'b0;
    end else begin
      r_lock_s1 <= locked_i;
      r_lock_s2 <= r_lock_s1;
      r_sw_s1   <= fetch_sw_i;
      r_sw_s2   <= r_sw_s1;
    end
  end

  croc_debounce #(
    .Cycles (DebounceCycles)
  ) u_debounce (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (r_sw_s2),
    .q_o   (w_sw_db)
  );

  // Lock loss beats restart, which beats each state's own exit.
  always_comb begin
    w_state_next = r_state;
    w_hold_clr   = 1'b0;
    w_run_clr    = 1'b0;
    if (!r_lock_s2) begin
      w_state_next = WAIT_LOCK;
    end else if (restart_i && (r_state != WAIT_LOCK)) begin
      w_state_next = RST_HOLD;
      w_hold_clr   = 1'b1;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_state_next = RST_HOLD;
          w_hold_clr   = 1'b1;
        end
        RST_HOLD: begin
          if (r_hold_cnt == c_hold_last) w_state_next = IDLE;
        end
        IDLE: begin
          if (w_sw_db) begin
            w_state_next = RUN;
            w_run_clr    = 1'b1;
          end
        end
        RUN: begin
          if (status_i) begin
            w_state_next = DONE;
          end else if (c_timeout_en && (r_run_cycles == c_timeout_last)) begin
            w_state_next = TIMEOUT;
          end else if (!w_sw_db) begin
            w_state_next = RST_HOLD;
            w_hold_clr   = 1'b1;
          end
        end
        DONE, TIMEOUT: begin
          if (!w_sw_db) begin
            w_state_next = RST_HOLD;
            w_hold_clr   = 1'b1;
          end
        end
        default: w_state_next = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= WAIT_LOCK;
      r_hold_cnt   <= '0;
      r_run_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hold_clr) begin
        r_hold_cnt <= '0;
      end else if (r_state == RST_HOLD) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      // Every cycle spent in RUN counts, including the one that leaves it.
      if (w_run_clr) begin
        r_run_cycles <= '0;
      end else if ((r_state == RUN) && (r_run_cycles != '1)) begin
        r_run_cycles <= r_run_cycles + 32'd1;
      end
    end
  end

  assign soc_rst_o    = (r_state == WAIT_LOCK) || (r_state == RST_HOLD);
  assign fetch_en_o   = (r_state == RUN) || (r_state == DONE) || (r_state == TIMEOUT);
  assign done_o       = (r_state == DONE);
  assign timeout_o    = (r_state == TIMEOUT);
  assign state_o      = r_state;
  assign run_cycles_o = r_run_cycles;

endmodule
`default_nettype wire

// File: doc/croc_boot_ctrl.md
CROC_BOOT_CTRL -- requirements
Module: croc_boot_ctrl

Interface
REQ-001 SHALL have parameter RstHoldCycles, default 32, the number of cycles SoC reset is held after clock lock or restart (must be at least 1).
REQ-002 SHALL have parameter DebounceCycles, default 20000, the number of consecutive stable cycles before the fetch switch value is accepted (must be at least 1).
REQ-003 SHALL have parameter TimeoutCycles, default 0, the RUN watchdog limit in cycles; 0 disables the watchdog.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, soc_clk.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port locked_i, input, 1 bit: clock-wizard lock, asynchronous.
REQ-007 SHALL have port fetch_sw_i, input, 1 bit: raw fetch-enable switch, asynchronous.
REQ-008 SHALL have port restart_i, input, 1 bit: synchronous single-cycle restart request.
REQ-009 SHALL have port status_i, input, 1 bit: SoC status_o (program finished).
REQ-010 SHALL have port soc_rst_o, output, 1 bit: active-high reset request toward the SoC reset generator.
REQ-011 SHALL have port fetch_en_o, output, 1 bit: SoC fetch enable.
REQ-012 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-013 SHALL have port timeout_o, output, 1 bit: high in TIMEOUT.
REQ-014 SHALL have port state_o, output, 3 bits: current FSM state encoding.
REQ-015 SHALL have port run_cycles_o, output, 32 bits: cycles spent in the last or current RUN.

Function
REQ-016 SHALL synchronize locked_i and fetch_sw_i through two flip-flops each before any use.
REQ-017 SHALL debounce the synchronized switch: the debounced value changes only after the synchronized value differs from it for DebounceCycles consecutive cycles; any mismatch break restarts the count.
REQ-018 SHALL implement states WAIT_LOCK=0, RST_HOLD=1, IDLE=2, RUN=3, DONE=4, TIMEOUT=5; state_o SHALL equal the current state.
REQ-019 WAIT_LOCK: soc_rst_o=1, fetch_en_o=0; on synchronized lock high, go to RST_HOLD.
REQ-020 RST_HOLD: soc_rst_o=1, fetch_en_o=0; hold count starts at 0 on entry; after exactly RstHoldCycles cycles in RST_HOLD, go to IDLE.
REQ-021 IDLE: soc_rst_o=0, fetch_en_o=0; on debounced switch high, go to RUN and clear run_cycles_o.
REQ-022 RUN: soc_rst_o=0, fetch_en_o=1; run_cycles_o increments each cycle and saturates at 2^32-1.
REQ-023 RUN exit: status_i high goes to DONE; otherwise, when TimeoutCycles is non-zero and run_cycles_o equals TimeoutCycles-1, go to TIMEOUT; status_i wins if both occur in the same cycle.
REQ-024 DONE and TIMEOUT: soc_rst_o=0, fetch_en_o=1, run_cycles_o frozen; on debounced switch low, go to RST_HOLD.
REQ-025 RUN with debounced switch low (and no status or timeout that cycle) SHALL go to RST_HOLD.
REQ-026 Priority in every state: synchronized lock low goes to WAIT_LOCK, above restart_i, above the state's own transition.
REQ-027 restart_i in any state other than WAIT_LOCK SHALL go to RST_HOLD; RST_HOLD re-entry restarts the hold count.
REQ-028 All outputs SHALL be registered or decoded only from registered state; soc_rst_o and fetch_en_o SHALL never be high together.

Reset
REQ-029 On rst_i high at a clock edge: state=WAIT_LOCK, soc_rst_o=1, fetch_en_o=0, done_o=0, timeout_o=0, run_cycles_o=0, all counters and synchronizers=0, debounced switch=0.
REQ-030 rst_i asserted mid-operation SHALL take effect on the next edge regardless of state.

Structure
REQ-031 The boot_state_e enum (3 bits) SHALL live in croc_pkg.
REQ-032 The debounce logic SHALL be a sub-module croc_debounce (parameter Cycles; ports clk_i, rst_i, d_i, q_o), instantiated once; the lock synchronizer SHALL be inline.

Verification (RstHoldCycles=4, DebounceCycles=3, TimeoutCycles=50)
REQ-033 Lock rises at cycle 0 -> soc_rst_o drops and state_o=2 at cycle 2 sync + 4 hold; fetch_en_o=0 throughout.
REQ-034 Switch glitch high for 2 cycles -> state stays IDLE; held high -> RUN after sync + 3 cycles, fetch_en_o=1.
REQ-035 status_i high after 10 RUN cycles -> DONE, done_o=1, run_cycles_o=10 frozen; switch low -> RST_HOLD, soc_rst_o=1 for 4 cycles.
REQ-036 No status in RUN -> TIMEOUT after 50 cycles, timeout_o=1; status_i and timeout in the same cycle -> DONE.
REQ-037 locked_i drops during RUN -> WAIT_LOCK, soc_rst_o=1, fetch_en_o=0 within 3 cycles; restart_i in DONE -> RST_HOLD.
REQ-038 rst_i pulsed in RUN -> all outputs at REQ-029 values on the next cycle.
